// File: rtl/mem_copy_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_copy_engine_if
// Brief   : Control and memory-port bundle for the block copy/fill engine.
// Revision: 1.0
// ============================================================================
interface mem_copy_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        len;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Engine side: owns the memory port, takes requests from the controller.
    modport master (
        input  start, mode, src_addr, dst_addr, len, fill_value, mem_rdata,
        output busy, done, mem_addr, mem_wdata, mem_write
    );

    // Controller and memory side.
    modport slave (
        output start, mode, src_addr, dst_addr, len, fill_value, mem_rdata,
        input  busy, done, mem_addr, mem_wdata, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module  : mem_copy_engine
// Brief   : Block copy (src->dst) or fill (const->dst) initiator for a
//           single-port synchronous 256x8 data memory.
// Revision: 1.0
// ============================================================================
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic          sysclk,
    input  wire logic          reset,
    mem_copy_engine_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        c_CNT_ONE  = 8'd1;

    state_t            state_q;
    logic              mode_q;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] fill_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_write_q;

    logic [ADDR_W-1:0] w_src_inc;
    logic [ADDR_W-1:0] w_dst_inc;

    assign w_src_inc = src_ptr_q + c_ADDR_ONE;
    assign w_dst_inc = dst_ptr_q + c_ADDR_ONE;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mem_write_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.len == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            mode_q    <= bus.mode;
                            src_ptr_q <= bus.src_addr;
                            dst_ptr_q <= bus.dst_addr;
                            cnt_q     <= bus.len;
                            fill_q    <= bus.fill_value;
                            busy_q    <= 1'b1;
                            if (bus.mode) begin
                                mem_addr_q  <= bus.dst_addr;
                                mem_wdata_q <= bus.fill_value;
                                mem_write_q <= 1'b1;
                                state_q     <= ST_WR;
                            end else begin
                                mem_addr_q  <= bus.src_addr;
                                state_q     <= ST_RD;
                            end
                        end
                    end
                end
                // Read address was presented last cycle; data lands next cycle.
                ST_RD: begin
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    mem_addr_q  <= dst_ptr_q;
                    mem_wdata_q <= bus.mem_rdata;
                    mem_write_q <= 1'b1;
                    state_q     <= ST_WR;
                end
                ST_WR: begin
                    cnt_q     <= cnt_q - c_CNT_ONE;
                    src_ptr_q <= w_src_inc;
                    dst_ptr_q <= w_dst_inc;
                    if (cnt_q == c_CNT_ONE) begin
                        mem_write_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (mode_q) begin
                        mem_addr_q  <= w_dst_inc;
                        mem_wdata_q <= fill_q;
                        state_q     <= ST_WR;
                    end else begin
                        mem_addr_q  <= w_src_inc;
                        mem_write_q <= 1'b0;
                        state_q     <= ST_RD;
                    end
                end
                default: begin
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = mem_write_q;
endmodule
`default_nettype wire
